// File: rtl/fifo_pack_pkg.sv
// fifo_pack shared constants.
// Widths, default depth and the pad byte used by the flush path.
package fifo_pack_pkg;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;
endpackage

// File: rtl/fifo_pack_mem.sv
// fifo_pack word store: DEPTH x WORD_W array,
// one synchronous write port and one registered read port.
module fifo_pack_mem
  import fifo_pack_pkg::*;
#(
  parameter int DEPTH  = fifo_pack_pkg::DEPTH,
  parameter int ADDR_W = fifo_pack_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // word storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, holds when idle
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_pack.sv
// Byte-to-word packing FIFO, low byte first, 32-word store.
// Optional macro FIFO_PACK_FLUSH_EN adds a flush port that pads a held byte.
module fifo_pack
  import fifo_pack_pkg::*;
#(
  parameter int DEPTH  = fifo_pack_pkg::DEPTH,
  parameter int ADDR_W = fifo_pack_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              input_valid,
  output logic              input_enable,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              output_enable,
  output logic              output_valid,
  output logic [WORD_W-1:0] data_out
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic              half;
  logic [BYTE_W-1:0] lo_byte;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic              accept;
  logic              commit_byte;
  logic              flush_commit;
  logic              commit;
  logic              rd;
  logic [WORD_W-1:0] wdata;

  // a low byte is always taken; the high byte waits for space
  assign input_enable = !half || (count != FULL);
  assign output_valid = (count != '0);

  assign accept      = input_valid && input_enable;
  assign commit_byte = accept && half;
  assign rd          = output_enable && output_valid;

`ifdef FIFO_PACK_FLUSH_EN
  assign flush_commit = flush && half && !accept
                        && (count != FULL);
`else
  assign flush_commit = 1'b0;
`endif

  assign commit = commit_byte || flush_commit;
  assign wdata  = commit_byte ? {data_in, lo_byte}
                              : {PAD_BYTE, lo_byte};

  // half-word register, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      half    <= 1'b0;
      lo_byte <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (accept && !half) begin
        lo_byte <= data_in;
        half    <= 1'b1;
      end
      if (commit) begin
        half   <= 1'b0;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_pack_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (commit && !rst),
    .waddr(wr_ptr),
    .wdata(wdata),
    .re   (rd),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule
